pe_row_sequencer: RTL and testbench

PE_ROW_SEQUENCER -- requirements
Module: pe_row_sequencer

---
 rtl/pe_row_sequencer_pkg.sv | 33 +++
 rtl/pe_row_sequencer_mac.sv | 31 +++
 rtl/pe_row_sequencer.sv | 139 +++++++++++++
 tb/tb_pe_row_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_row_sequencer_pkg.sv
// Shared parameters, clog2 helper and FSM encoding for the PE row sequencer.
// PSUM_SAT_EN (see pe_row_sequencer.sv) clamps the reported row sum to 16 bits.
package pe_row_sequencer_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int KERNEL_WIDTH = 3;
  localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH;
  localparam int IF_WIDTH     = 16;
  localparam int PSUM_WIDTH   = 24;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int IDX_W  = clog2(IF_WIDTH);
  localparam int SEG_W  = clog2(KERNEL_WIDTH);
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'(32767);
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = PSUM_WIDTH'(-32768);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/pe_row_sequencer_mac.sv
// pe_mac_lane: selects one weight lane and forms the signed 8x8 product.
// Out-of-range lane selects yield a zero product and raise idx_err.
module pe_mac_lane
  import pe_row_sequencer_pkg::*;
(
  input  logic        [DATA_WIDTH*KERNEL_SIZE-1:0] parallel_out,
  input  logic signed [DATA_WIDTH-1:0]             serial_out,
  input  logic        [IDX_W-1:0]                  wei_index,
  output logic signed [PROD_W-1:0]                 product,
  output logic                                     idx_err
);

  localparam logic [IDX_W-1:0] LANE_MAX = IDX_W'(KERNEL_SIZE - 1);

  logic signed [DATA_WIDTH-1:0] lane;
  logic signed [PROD_W-1:0]     lane_ext;
  logic signed [PROD_W-1:0]     ser_ext;

  always_comb begin
    lane = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      if (wei_index == IDX_W'(k)) lane = parallel_out[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign idx_err  = (wei_index > LANE_MAX);
  assign lane_ext = {{(PROD_W-DATA_WIDTH){lane[DATA_WIDTH-1]}}, lane};
  assign ser_ext  = {{(PROD_W-DATA_WIDTH){serial_out[DATA_WIDTH-1]}}, serial_out};
  assign product  = idx_err ? '0 : lane_ext * ser_ext;

endmodule

// File: rtl/pe_row_sequencer.sv
// Sequences MAC beats into segments and segments into output rows; optional
// PSUM_SAT_EN macro saturates psum_out to the signed 16-bit range.
// state | meaning
// IDLE  | waiting for first beat of a segment
// ACC   | accumulating remaining beats of the segment
// FIN   | one-cycle segment finish, row result emitted when row completes
module pe_row_sequencer
  import pe_row_sequencer_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     mode,
  input  logic                                     en,
  input  logic        [DATA_WIDTH*KERNEL_SIZE-1:0] parallel_out,
  input  logic signed [DATA_WIDTH-1:0]             serial_out,
  input  logic        [IDX_W-1:0]                  wei_index,
  input  logic        [IDX_W-1:0]                  row_index,
  input  logic        [IDX_W-1:0]                  row_val_num,
  input  logic                                     zero_flag,
  output logic                                     row_finish_done_0,
  output logic                                     row_cal_done,
  output logic signed [PSUM_WIDTH-1:0]             psum_out,
  output logic                                     psum_valid,
  output logic        [IDX_W-1:0]                  psum_row,
  output logic                                     err
);

  state_t state, state_n;

  logic signed [PSUM_WIDTH-1:0] acc;
  logic        [IDX_W-1:0]      beat_cnt;
  logic        [IDX_W-1:0]      n_cap;
  logic        [IDX_W-1:0]      row_tag;
  logic        [SEG_W-1:0]      seg_cnt;
  logic                         mode_cap;
  logic                         err_q;

  logic                         cap_en;
  logic                         mac_en;
  logic                         fin;
  logic                         cal;

  logic signed [PROD_W-1:0]     product;
  logic                         idx_err;
  logic signed [PSUM_WIDTH-1:0] prod_ext;
  logic signed [PSUM_WIDTH-1:0] psum_res;

  pe_mac_lane u_mac (
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .wei_index    (wei_index),
    .product      (product),
    .idx_err      (idx_err)
  );

  assign prod_ext = {{(PSUM_WIDTH-PROD_W){product[PROD_W-1]}}, product};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    mac_en  = 1'b0;
    fin     = 1'b0;
    cal     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          cap_en = 1'b1;
          if (zero_flag || (row_val_num == '0)) begin
            state_n = ST_FIN;
          end else begin
            mac_en  = 1'b1;
            state_n = (row_val_num == IDX_W'(1)) ? ST_FIN : ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (en) begin
          mac_en = 1'b1;
          if ((beat_cnt + IDX_W'(1)) == n_cap) state_n = ST_FIN;
        end
      end
      ST_FIN: begin
        fin     = 1'b1;
        cal     = !mode_cap || (seg_cnt == SEG_W'(KERNEL_WIDTH - 1));
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      beat_cnt <= '0;
      n_cap    <= '0;
      row_tag  <= '0;
      seg_cnt  <= '0;
      mode_cap <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (cap_en) begin
        row_tag  <= row_index;
        n_cap    <= row_val_num;
        mode_cap <= mode;
        beat_cnt <= mac_en ? IDX_W'(1) : '0;
      end else if (mac_en) begin
        beat_cnt <= beat_cnt + IDX_W'(1);
      end
      if (mac_en) acc <= acc + prod_ext;
      else if (cal) acc <= '0;
      if (fin) seg_cnt <= cal ? '0 : seg_cnt + SEG_W'(1);
      // Beats arriving during FIN are dropped, not queued.
      if ((fin && en) || (mac_en && idx_err)) err_q <= 1'b1;
    end
  end

`ifdef PSUM_SAT_EN
  always_comb begin
    psum_res = acc;
    if (acc > SAT_MAX)      psum_res = SAT_MAX;
    else if (acc < SAT_MIN) psum_res = SAT_MIN;
  end
`else
  assign psum_res = acc;
`endif

  assign row_finish_done_0 = fin;
  assign row_cal_done      = cal;
  assign psum_valid        = cal;
  assign psum_out          = cal ? psum_res : '0;
  assign psum_row          = cal ? row_tag : '0;
  assign err               = err_q;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Directed self-checking bench for pe_row_sequencer; lanes hold k in lane k
// unless a scenario overrides lane 0.
module tb_pe_row_sequencer;

  logic               clk;
  logic               reset;
  logic               mode;
  logic               en;
  logic [71:0]        parallel_out;
  logic signed [7:0]  serial_out;
  logic [3:0]         wei_index;
  logic [3:0]         row_index;
  logic [3:0]         row_val_num;
  logic               zero_flag;
  logic               row_finish_done_0;
  logic               row_cal_done;
  logic signed [23:0] psum_out;
  logic               psum_valid;
  logic [3:0]         psum_row;
  logic               err;

  int checks;
  int failures;

  pe_row_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .mode              (mode),
    .en                (en),
    .parallel_out      (parallel_out),
    .serial_out        (serial_out),
    .wei_index         (wei_index),
    .row_index         (row_index),
    .row_val_num       (row_val_num),
    .zero_flag         (zero_flag),
    .row_finish_done_0 (row_finish_done_0),
    .row_cal_done      (row_cal_done),
    .psum_out          (psum_out),
    .psum_valid        (psum_valid),
    .psum_row          (psum_row),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic signed [7:0] lane0);
    for (int k = 0; k < 9; k++) parallel_out[k*8 +: 8] = 8'(k);
    parallel_out[7:0] = lane0;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Drives one whole segment back to back; returns #1 after the edge entering FIN.
  task automatic run_seg(input int n, input logic zf, input logic [3:0] row,
                         input logic signed [7:0] ser, input logic [3:0] lane);
    row_val_num = 4'(n);
    zero_flag   = zf;
    row_index   = row;
    serial_out  = ser;
    wei_index   = lane;
    en          = 1'b1;
    if (zf || n == 0) begin
      tick();
    end else begin
      for (int i = 0; i < n; i++) tick();
    end
    en        = 1'b0;
    zero_flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({row_finish_done_0, row_cal_done, psum_valid, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {row_finish_done_0, row_cal_done, psum_valid, err});
    end
    checks++;
    if (psum_out !== 24'sd0 || psum_row !== 4'd0) begin
      failures++;
      $display("FAIL reset_data psum_out=%0d psum_row=%0d want 0 0", psum_out, psum_row);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mode1_row();
    do_reset();
    mode = 1'b1;
    run_seg(2, 1'b0, 4'd1, 8'sd2, 4'd3);
    checks++;
    if (row_finish_done_0 !== 1'b1 || row_cal_done !== 1'b0) begin
      failures++;
      $display("FAIL m1_seg0 fin=%b cal=%b want 1 0", row_finish_done_0, row_cal_done);
    end
    tick();
    run_seg(0, 1'b1, 4'd2, 8'sd2, 4'd3);
    checks++;
    if (row_finish_done_0 !== 1'b1 || row_cal_done !== 1'b0 || psum_valid !== 1'b0) begin
      failures++;
      $display("FAIL m1_seg1 fin=%b cal=%b valid=%b want 1 0 0", row_finish_done_0, row_cal_done, psum_valid);
    end
    tick();
    run_seg(3, 1'b0, 4'd7, 8'sd2, 4'd3);
    checks++;
    if (row_finish_done_0 !== 1'b1 || row_cal_done !== 1'b1 || psum_valid !== 1'b1) begin
      failures++;
      $display("FAIL m1_seg2 fin=%b cal=%b valid=%b want 1 1 1", row_finish_done_0, row_cal_done, psum_valid);
    end
    checks++;
    if (psum_out !== 24'sd30 || psum_row !== 4'd7) begin
      failures++;
      $display("FAIL m1_psum psum_out=%0d row=%0d want 30 7", psum_out, psum_row);
    end
    tick();
  endtask

  task automatic test_mode0_long();
    mode = 1'b0;
    run_seg(10, 1'b0, 4'd4, -8'sd1, 4'd5);
    checks++;
    if (row_finish_done_0 !== 1'b1 || row_cal_done !== 1'b1) begin
      failures++;
      $display("FAIL m0_pulse fin=%b cal=%b want 1 1", row_finish_done_0, row_cal_done);
    end
    checks++;
    if (psum_out !== -24'sd50 || psum_row !== 4'd4 || err !== 1'b0) begin
      failures++;
      $display("FAIL m0_psum psum_out=%0d row=%0d err=%b want -50 4 0", psum_out, psum_row, err);
    end
    tick();
    checks++;
    if (row_finish_done_0 !== 1'b0 || psum_valid !== 1'b0) begin
      failures++;
      $display("FAIL m0_one_cycle fin=%b valid=%b want 0 0", row_finish_done_0, psum_valid);
    end
  endtask

  task automatic test_en_in_fin();
    mode = 1'b0;
    run_seg(1, 1'b0, 4'd2, 8'sd1, 4'd2);
    checks++;
    if (psum_out !== 24'sd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL fin_first psum_out=%0d err=%b want 2 0", psum_out, err);
    end
    row_val_num = 4'd1;
    serial_out  = 8'sd5;
    wei_index   = 4'd8;
    en          = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (err !== 1'b1 || row_finish_done_0 !== 1'b0) begin
      failures++;
      $display("FAIL fin_drop err=%b fin=%b want 1 0", err, row_finish_done_0);
    end
    tick();
    checks++;
    if (row_finish_done_0 !== 1'b0) begin
      failures++;
      $display("FAIL fin_no_seg fin=%b want 0", row_finish_done_0);
    end
    run_seg(2, 1'b0, 4'd6, 8'sd3, 4'd1);
    checks++;
    if (psum_out !== 24'sd6 || psum_row !== 4'd6 || err !== 1'b1) begin
      failures++;
      $display("FAIL fin_next psum_out=%0d row=%0d err=%b want 6 6 1", psum_out, psum_row, err);
    end
    tick();
  endtask

  task automatic test_bad_lane();
    do_reset();
    mode        = 1'b0;
    row_val_num = 4'd2;
    row_index   = 4'd5;
    zero_flag   = 1'b0;
    serial_out  = 8'sd3;
    wei_index   = 4'd12;
    en          = 1'b1;
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL lane_err err=%b want 1", err);
    end
    wei_index = 4'd6;
    tick();
    en = 1'b0;
    checks++;
    if (psum_valid !== 1'b1 || psum_out !== 24'sd18) begin
      failures++;
      $display("FAIL lane_psum valid=%b psum_out=%0d want 1 18", psum_valid, psum_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode        = 1'b0;
    row_val_num = 4'd5;
    row_index   = 4'd9;
    zero_flag   = 1'b0;
    serial_out  = 8'sd9;
    wei_index   = 4'd1;
    en          = 1'b1;
    tick();
    tick();
    #2;
    en    = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0 || row_finish_done_0 !== 1'b0 || psum_out !== 24'sd0) begin
      failures++;
      $display("FAIL mid_reset err=%b fin=%b psum_out=%0d want 0 0 0", err, row_finish_done_0, psum_out);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (row_finish_done_0 !== 1'b0 || row_cal_done !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_pulse cycle=%0d fin=%b cal=%b want 0 0", i, row_finish_done_0, row_cal_done);
      end
    end
    run_seg(1, 1'b0, 4'd3, 8'sd4, 4'd4);
    checks++;
    if (psum_valid !== 1'b1 || psum_out !== 24'sd16 || psum_row !== 4'd3) begin
      failures++;
      $display("FAIL mid_fresh valid=%b psum_out=%0d row=%0d want 1 16 3", psum_valid, psum_out, psum_row);
    end
    tick();
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1;
    run_seg(1, 1'b0, 4'd1, 8'sd1, 4'd1);
    mode = 1'b0;
    #1;
    checks++;
    if (row_finish_done_0 !== 1'b1 || row_cal_done !== 1'b0) begin
      failures++;
      $display("FAIL sw_first fin=%b cal=%b want 1 0", row_finish_done_0, row_cal_done);
    end
    tick();
    run_seg(1, 1'b0, 4'd2, 8'sd1, 4'd2);
    checks++;
    if (row_cal_done !== 1'b1 || psum_out !== 24'sd3 || psum_row !== 4'd2) begin
      failures++;
      $display("FAIL sw_second cal=%b psum_out=%0d row=%0d want 1 3 2", row_cal_done, psum_out, psum_row);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic signed [23:0] exp_big;
`ifdef PSUM_SAT_EN
    exp_big = 24'sd32767;
`else
    exp_big = 24'sd737280;
`endif
    do_reset();
    mode = 1'b1;
    set_lanes(-8'sd128);
    for (int s = 0; s < 3; s++) begin
      run_seg(15, 1'b0, 4'd9, -8'sd128, 4'd0);
      checks++;
      if (row_finish_done_0 !== 1'b1 || row_cal_done !== (s == 2)) begin
        failures++;
        $display("FAIL sat_seg%0d fin=%b cal=%b", s, row_finish_done_0, row_cal_done);
      end
      if (s == 2) begin
        checks++;
        if (psum_out !== exp_big) begin
          failures++;
          $display("FAIL sat_psum psum_out=%0d want %0d", psum_out, exp_big);
        end
      end
      tick();
    end
    set_lanes(8'sd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    mode        = 1'b0;
    en          = 1'b0;
    serial_out  = '0;
    wei_index   = '0;
    row_index   = '0;
    row_val_num = '0;
    zero_flag   = 1'b0;
    set_lanes(8'sd0);
    test_reset();
    test_mode1_row();
    test_mode0_long();
    test_en_in_fin();
    test_bad_lane();
    test_reset_mid();
    test_mode_switch();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
